// File: rtl/alu_seq_ctrl_if.sv
// Handshake and control bundle between the sequencer, instruction memory
// and the 16-bit datapath.
interface alu_seq_ctrl_if #(
  parameter int WORD_SIZE = 16
);
  logic [3:0]           opcode;
  logic [5:0]           func;
  logic                 mem_ready;
  logic                 readM;
  logic                 ir_write;
  logic                 alu_en;
  logic                 alu_src_imm;
  logic                 reg_write;
  logic                 wb_dst_rd;
  logic                 pc_write;
  logic                 pc_src_jmp;
  logic                 out_en;
  logic                 illegal;
  logic                 halted;
  logic [WORD_SIZE-1:0] num_inst;

  modport master (
    input  opcode, func, mem_ready,
    output readM, ir_write, alu_en, alu_src_imm, reg_write, wb_dst_rd,
           pc_write, pc_src_jmp, out_en, illegal, halted, num_inst
  );

  modport slave (
    output opcode, func, mem_ready,
    input  readM, ir_write, alu_en, alu_src_imm, reg_write, wb_dst_rd,
           pc_write, pc_src_jmp, out_en, illegal, halted, num_inst
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the 16-bit datapath.
// All enables are decoded from the state register, so reset kills them at once.
module alu_seq_ctrl #(
  parameter int WORD_SIZE = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  localparam logic [3:0] OP_R   = 4'd15;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;

  logic is_add, is_adi, is_lhi, is_jmp, is_wwd, is_hlt, is_alu;
  logic rd_m, ir_w, alu_e, src_imm, reg_w, dst_rd, pc_w, src_jmp, out_e, retire;

  always_comb begin
    is_add = (bus.opcode == OP_R) && (bus.func == FN_ADD);
    is_wwd = (bus.opcode == OP_R) && (bus.func == FN_WWD);
    is_hlt = (bus.opcode == OP_R) && (bus.func == FN_HLT);
    is_adi = (bus.opcode == OP_ADI);
    is_lhi = (bus.opcode == OP_LHI);
    is_jmp = (bus.opcode == OP_JMP);
    is_alu = is_add | is_adi | is_lhi;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    rd_m      = 1'b0;
    ir_w      = 1'b0;
    alu_e     = 1'b0;
    src_imm   = 1'b0;
    reg_w     = 1'b0;
    dst_rd    = 1'b0;
    pc_w      = 1'b0;
    src_jmp   = 1'b0;
    out_e     = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        rd_m = 1'b1;
        if (bus.mem_ready) begin
          ir_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu) begin
          alu_e   = 1'b1;
          src_imm = ~is_add;
          state_d = S_WB;
        end else if (is_jmp) begin
          pc_w    = 1'b1;
          src_jmp = 1'b1;
          state_d = S_FETCH;
        end else if (is_wwd) begin
          out_e   = 1'b1;
          pc_w    = 1'b1;
          state_d = S_FETCH;
        end else if (is_hlt) begin
          // HLT retires without moving the PC
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          pc_w      = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        reg_w   = 1'b1;
        dst_rd  = is_add;
        pc_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + WORD_SIZE'(pc_w | retire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.readM       = rd_m;
  assign bus.ir_write    = ir_w;
  assign bus.alu_en      = alu_e;
  assign bus.alu_src_imm = src_imm;
  assign bus.reg_write   = reg_w;
  assign bus.wb_dst_rd   = dst_rd;
  assign bus.pc_write    = pc_w;
  assign bus.pc_src_jmp  = src_jmp;
  assign bus.out_en      = out_e;
  assign bus.illegal     = illegal_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.num_inst    = cnt_q;

endmodule
